dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder at the far end of the processor's data port. The `MIPS` core drives `direccion` (byte address) and `palabra` (store data) and consumes `leer_dato`. This block accepts those requests through a req/ready handshake, inserts a programmable number of wait states, performs byte-lane writes into word storage, and returns read data. It replaces the zero-latency combinational data memory, so the core can be verified against realistic memory stalls.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words stored; power of two, 16..4096.
- `WAIT_CYCLES`, 2: wait states inserted between request acceptance and `ready`; 0..15.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to `DEPTH_WORDS*4`.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  1  request valid; held high with fields stable until `ready`.
- `we`  in  1  1 = store, 0 = load.
- `be`  in  4  byte enables for stores; bit i selects `palabra[8i+7:8i]`; ignored on loads.
- `direccion`  in  32  byte address; bits [1:0] ignored (word access).
- `palabra`  in  32  store data.
- `leer_dato`  out  32  load data; valid in the `ready` cycle of a load, then held.
- `ready`  out  1  one-cycle completion pulse.
- `err`  out  1  out-of-range flag, pulses with `ready` (present only with `DMEM_RANGE_CHECK_EN`).

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req`=1 latches `we`, `be`, word index (`(direccion-BASE_ADDR)>>2`), and `palabra`, and loads the wait counter with `WAIT_CYCLES`. Next state is WAIT if `WAIT_CYCLES`>0, otherwise RESP.
- WAIT: counter decrements each cycle. At 1 → RESP. `req`/field changes are ignored here.
- RESP: store: lanes with `be[i]`=1 are written and others are unchanged. Load: the word is copied to `leer_dato`. `ready`=1 for exactly this cycle. Next state is IDLE.
- Back-to-back: a request held or re-asserted in the cycle after RESP is accepted; IDLE lasts at least one cycle between transactions.
- `be`=4'b0000 store: completes normally, memory unchanged.
- Index ≥ `DEPTH_WORDS` without the macro: the index wraps modulo `DEPTH_WORDS` (upper bits truncated).
- Storage array is not reset; contents persist across `rst`.

## Timing
- Reset values: `ready`=0, `leer_dato`=32'h0, `err`=0, FSM=IDLE, counter=0.
- Latency: `req` sampled high at edge N → `ready` high in cycle N+1+`WAIT_CYCLES`.
- Throughput: one transaction per `WAIT_CYCLES`+2 cycles.
- Store takes effect at the RESP edge; a load in the next transaction returns the new value.
- `leer_dato` changes only at a load's RESP edge; stores and wait cycles leave it unchanged.
- `rst` mid-transaction (WAIT or RESP): the transaction is aborted, no write occurs, `ready` stays 0, FSM returns to IDLE next cycle.
- `rst` and `req` high together: reset wins; the request is not accepted.

## Configuration
- `DMEM_RANGE_CHECK_EN` defined: the `err` port exists. An index ≥ `DEPTH_WORDS` or an address below `BASE_ADDR` still completes with `ready`, and `err`=1 in that cycle. Stores are suppressed and loads return 32'hDEAD_BEEF.
- Not defined: there is no `err` port and addresses wrap as described above.

## Structure
- Package `dmem_pkg`: FSM state enum (`DMEM_IDLE`, `DMEM_WAIT`, `DMEM_RESP`), constant `DMEM_ERR_WORD` = 32'hDEAD_BEEF, and a typedef for the 4-bit byte-enable.
- Sub-module `dmem_array`: four byte-lane storage banks with a synchronous write enable per lane and a combinational read. The FSM, counter and handshake stay in `dmem_responder`.

## Test plan
- Store `palabra`=32'h1234_5678 to 0x10, `be`=4'hF, `WAIT_CYCLES`=2, then load 0x10 → `ready` 3 cycles after each acceptance; `leer_dato`=32'h1234_5678.
- Store 32'hAABB_CCDD to 0x10 with `be`=4'b0101 over the previous word → load returns 32'h12BB_56DD.
- `WAIT_CYCLES`=0, `req` held high continuously → alternating `ready` every 2 cycles; no request is lost or duplicated.
- Assert `rst` during WAIT of a store of 32'hFFFF_FFFF to 0x20 → `ready` never pulses; a subsequent load of 0x20 returns the prior contents.
- With `DMEM_RANGE_CHECK_EN` and `DEPTH_WORDS`=256, load 0x400 → `ready`=1 and `err`=1 in the same cycle; `leer_dato`=32'hDEAD_BEEF. Without the macro, the same load returns the word at 0x000.
- After reset, before any load → `leer_dato`=32'h0 and `ready`=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

  typedef logic [3:0] dmem_be_t;

  localparam logic [31:0] DMEM_ERR_WORD = 32'hDEAD_BEEF;

endpackage

// File: rtl/dmem_array.sv
// Word storage as four byte-lane banks: per-lane synchronous write, combinational read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  dmem_be_t                       lane_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] bank [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (lane_we[l]) begin
        bank[idx] <= wdata[8*l +: 8];
      end
    end

    assign rdata[8*l +: 8] = bank[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: req/ready handshake, WAIT_CYCLES wait states, byte-lane stores.
// Optional out-of-range detection and err port with DMEM_RANGE_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  dmem_be_t    be,
  input  logic [31:0] direccion,
  input  logic [31:0] palabra,
  output logic [31:0] leer_dato,
`ifdef DMEM_RANGE_CHECK_EN
  output logic        err,
`endif
  output logic        ready
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  dmem_state_e        state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               ready_q;
  logic [31:0]        leer_dato_q;
  logic               err_q;

  logic               we_q;
  dmem_be_t           be_q;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        wdata_q;
  logic               oor_q;

  logic [31:0]        offset;
  logic               oor_d;
  logic               oor_eff;
  logic               accept;
  logic               in_resp;
  dmem_be_t           lane_we;
  logic [31:0]        rdata;

  // Address translation is evaluated at acceptance and frozen with the request.
  assign offset  = direccion - BASE_ADDR;
  assign oor_d   = (direccion < BASE_ADDR) || ({2'b00, offset[31:2]} >= 32'(DEPTH_WORDS));
  assign accept  = (state_q == DMEM_IDLE) && req;
  assign in_resp = (state_q == DMEM_RESP);

`ifdef DMEM_RANGE_CHECK_EN
  assign oor_eff = oor_q;
  assign err     = err_q;
`else
  assign oor_eff = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{offset[1:0], oor_q, err_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      DMEM_IDLE: begin
        if (req) begin
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYCLES > 0) ? DMEM_WAIT : DMEM_RESP;
        end
      end
      DMEM_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = DMEM_RESP;
        end
      end
      DMEM_RESP: state_d = DMEM_IDLE;
      default:   state_d = DMEM_IDLE;
    endcase
  end

  // Control state: reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DMEM_IDLE;
      cnt_q       <= 4'd0;
      ready_q     <= 1'b0;
      leer_dato_q <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= in_resp;
      err_q   <= in_resp && oor_eff;
      if (in_resp && !we_q) begin
        leer_dato_q <= oor_eff ? DMEM_ERR_WORD : rdata;
      end
    end
  end

  // Request fields are datapath only and need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= we;
      be_q    <= be;
      idx_q   <= offset[IDX_W+1:2];
      wdata_q <= palabra;
      oor_q   <= oor_d;
    end
  end

  assign lane_we = (in_resp && we_q && !rst && !oor_eff) ? be_q : 4'b0000;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk    (clk),
    .lane_we(lane_we),
    .idx    (idx_q),
    .wdata  (wdata_q),
    .rdata  (rdata)
  );

  assign ready     = ready_q;
  assign leer_dato = leer_dato_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;

  logic        req,  we;
  logic [3:0]  be;
  logic [31:0] direccion, palabra, leer_dato;
  logic        ready;
  logic        err;

  logic        req0, we0;
  logic [3:0]  be0;
  logic [31:0] direccion0, palabra0, leer_dato0;
  logic        ready0;
  logic        err0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .be(be),
    .direccion(direccion), .palabra(palabra), .leer_dato(leer_dato),
`ifdef DMEM_RANGE_CHECK_EN
    .err(err),
`endif
    .ready(ready)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .be(be0),
    .direccion(direccion0), .palabra(palabra0), .leer_dato(leer_dato0),
`ifdef DMEM_RANGE_CHECK_EN
    .err(err0),
`endif
    .ready(ready0)
  );

`ifndef DMEM_RANGE_CHECK_EN
  assign err  = 1'b0;
  assign err0 = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One transaction on instance 0 (sel=0, WAIT_CYCLES=2) or 1 (sel=1, WAIT_CYCLES=0).
  task automatic txn(input bit sel, input logic w, input logic [3:0] b,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output int lat, output logic e);
    @(negedge clk);
    if (sel) begin
      req0 = 1'b1; we0 = w; be0 = b; direccion0 = a; palabra0 = d;
    end else begin
      req = 1'b1; we = w; be = b; direccion = a; palabra = d;
    end
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if ((sel ? ready0 : ready) === 1'b1) begin
        lat = k - 1;
        break;
      end
    end
    rd = sel ? leer_dato0 : leer_dato;
    e  = sel ? err0 : err;
    if (sel) req0 = 1'b0; else req = 1'b0;
    @(negedge clk);
    chk("rdy_pulse", {31'b0, (sel ? ready0 : ready)}, 32'd0);
  endtask

  logic [31:0] rd;
  int          lat;
  logic        e;
  int          n;

  initial begin
    rst = 1'b1;
    req = 1'b0; we = 1'b0; be = 4'h0; direccion = 32'h0; palabra = 32'h0;
    req0 = 1'b0; we0 = 1'b0; be0 = 4'h0; direccion0 = 32'h0; palabra0 = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_leer", leer_dato, 32'h0);
    rst = 1'b0;

    // Full-word store then load, latency three cycles from acceptance
    txn(0, 1'b1, 4'hF, 32'h10, 32'h1234_5678, rd, lat, e);
    chk("st_lat", lat, 32'd3);
    chk("st_leer_hold", rd, 32'h0);
    txn(0, 1'b0, 4'h0, 32'h10, 32'h0, rd, lat, e);
    chk("ld_lat", lat, 32'd3);
    chk("ld_data", rd, 32'h1234_5678);
    chk("ld_err", {31'b0, e}, 32'd0);

    // Partial store on lanes 0 and 2
    txn(0, 1'b1, 4'b0101, 32'h10, 32'hAABB_CCDD, rd, lat, e);
    chk("pst_leer_hold", rd, 32'h1234_5678);
    txn(0, 1'b0, 4'h0, 32'h10, 32'h0, rd, lat, e);
    chk("pst_data", rd, 32'h12BB_56DD);

    // Store with no lanes enabled leaves memory alone
    txn(0, 1'b1, 4'b0000, 32'h10, 32'hFFFF_FFFF, rd, lat, e);
    chk("be0_lat", lat, 32'd3);
    txn(0, 1'b0, 4'h0, 32'h10, 32'h0, rd, lat, e);
    chk("be0_data", rd, 32'h12BB_56DD);

    // Reset during WAIT of a store aborts it
    txn(0, 1'b1, 4'hF, 32'h20, 32'h0BAD_F00D, rd, lat, e);
    @(negedge clk);
    req = 1'b1; we = 1'b1; be = 4'hF; direccion = 32'h20; palabra = 32'hFFFF_FFFF;
    @(negedge clk);
    rst = 1'b1; req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ready) n++;
    end
    chk("rst_wait_noready", n, 32'd0);
    chk("rst_wait_leer", leer_dato, 32'h0);
    txn(0, 1'b0, 4'h0, 32'h20, 32'h0, rd, lat, e);
    chk("rst_wait_data", rd, 32'h0BAD_F00D);

    // Reset and request together: request is dropped
    @(negedge clk);
    rst = 1'b1; req = 1'b1; we = 1'b1; be = 4'hF; direccion = 32'h20; palabra = 32'h5555_5555;
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ready) n++;
    end
    chk("rst_req_noready", n, 32'd0);
    txn(0, 1'b0, 4'h0, 32'h20, 32'h0, rd, lat, e);
    chk("rst_req_data", rd, 32'h0BAD_F00D);

    // Index beyond DEPTH_WORDS
    txn(0, 1'b1, 4'hF, 32'h000, 32'hCAFE_0001, rd, lat, e);
    txn(0, 1'b0, 4'h0, 32'h400, 32'h0, rd, lat, e);
    chk("oor_lat", lat, 32'd3);
`ifdef DMEM_RANGE_CHECK_EN
    chk("oor_err", {31'b0, e}, 32'd1);
    chk("oor_data", rd, 32'hDEAD_BEEF);
    txn(0, 1'b1, 4'hF, 32'h400, 32'h7777_7777, rd, lat, e);
    chk("oor_st_err", {31'b0, e}, 32'd1);
    txn(0, 1'b0, 4'h0, 32'h000, 32'h0, rd, lat, e);
    chk("oor_st_suppr", rd, 32'hCAFE_0001);
    chk("oor_inr_err", {31'b0, e}, 32'd0);
`else
    chk("wrap_data", rd, 32'hCAFE_0001);
`endif

    // Zero wait states, request held high: ready every other cycle
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; be0 = 4'hF; direccion0 = 32'h0; palabra0 = 32'd100;
    n = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("b2b_rdy", {31'b0, ready0}, (k % 2 == 0) ? 32'd1 : 32'd0);
      if (ready0) begin
        n++;
        if (n < 8) begin
          direccion0 = 32'(4 * n);
          palabra0   = 32'(100 + n);
        end else begin
          req0 = 1'b0;
        end
      end
    end
    chk("b2b_cnt", n, 32'd8);
    for (int i = 0; i < 8; i++) begin
      txn(1, 1'b0, 4'h0, 32'(4 * i), 32'h0, rd, lat, e);
      chk("b2b_lat", lat, 32'd1);
      chk("b2b_data", rd, 32'(100 + i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
